// File: rtl/rs232in_hex_pkg.sv
// Shared definitions for the RS232 hex line receiver: receiver FSM encoding,
// line-control characters and the ASCII hex-digit decoder.
package rs232in_hex_pkg;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      START    = 3'd1,
      DATA     = 3'd2,
      STOP     = 3'd3,
      WAITHIGH = 3'd4
   } rx_state_t;

   localparam logic [7:0] CR = 8'd13;
   localparam logic [7:0] LF = 8'd10;

   // Returns {is_hex, nibble}. Letters map via low nibble + 9 ('A'/'a' -> 1 + 9).
   function automatic logic [4:0] hex_decode(input logic [7:0] c);
      logic [4:0] r;
      r = 5'd0;
      if (c >= 8'h30 && c <= 8'h39)
         r = {1'b1, c[3:0]};
      else if ((c >= 8'h41 && c <= 8'h46) || (c >= 8'h61 && c <= 8'h66))
         r = {1'b1, c[3:0] + 4'd9};
      return r;
   endfunction

endpackage

// File: rtl/rs232in_hex_if.sv
// Serial input plus received-byte and parsed-word outputs of rs232in_hex.
// master = the receiver/parser side, slave = whoever drives the line and consumes results.
interface rs232in_hex_if;
   logic        serial_in;
   logic [7:0]  byte_data;
   logic        byte_valid;
   logic        framing_error;
   logic [35:0] word;
   logic [3:0]  nibbles;
   logic        word_overflow;
   logic        word_valid;

   modport master (
      input  serial_in,
      output byte_data, byte_valid, framing_error,
      output word, nibbles, word_overflow, word_valid
   );

   modport slave (
      output serial_in,
      input  byte_data, byte_valid, framing_error,
      input  word, nibbles, word_overflow, word_valid
   );
endinterface

// File: rtl/rs232in.sv
// 8N1 UART receiver; byte_valid/framing_error pulse one cycle after the stop-bit sample.
// No backpressure: each byte is presented for a single cycle and must be taken then.
module rs232in
   import rs232in_hex_pkg::*;
#(
   parameter int frequency = 50_000_000,
   parameter int bps       = 115_200
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       serial_in,
   output logic [7:0] byte_data,
   output logic       byte_valid,
   output logic       framing_error
);
   localparam int P  = frequency / bps;
   localparam int H  = P / 2;
   localparam int CW = $clog2(P + 1);

   rx_state_t     state, state_nxt;
   logic [1:0]    sync_q;
   logic          prev_q;
   logic [CW-1:0] cnt, cnt_nxt;
   logic [2:0]    bit_idx, bit_nxt;
   logic [7:0]    shreg, shreg_nxt;
   logic [7:0]    data_nxt;
   logic          vld_nxt, ferr_nxt;
   logic          rxd, fall, expired;

   assign rxd     = sync_q[1];
   assign fall    = prev_q & ~rxd;
   // A load of N therefore expires after exactly N cycles
   assign expired = (cnt <= CW'(1));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync_q        <= 2'b11;
         prev_q        <= 1'b1;
         state         <= IDLE;
         cnt           <= '0;
         bit_idx       <= '0;
         shreg         <= '0;
         byte_data     <= '0;
         byte_valid    <= 1'b0;
         framing_error <= 1'b0;
      end else begin
         sync_q        <= {sync_q[0], serial_in};
         prev_q        <= rxd;
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bit_idx       <= bit_nxt;
         shreg         <= shreg_nxt;
         byte_data     <= data_nxt;
         byte_valid    <= vld_nxt;
         framing_error <= ferr_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      bit_nxt   = bit_idx;
      shreg_nxt = shreg;
      data_nxt  = byte_data;
      vld_nxt   = 1'b0;
      ferr_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_nxt = START;
               cnt_nxt   = CW'(H);
            end
         end
         START: begin
            if (!expired) begin
               cnt_nxt = cnt - CW'(1);
            end else if (!rxd) begin
               state_nxt = DATA;
               cnt_nxt   = CW'(P);
               bit_nxt   = '0;
            end else begin
               state_nxt = IDLE;
            end
         end
         DATA: begin
            if (!expired) begin
               cnt_nxt = cnt - CW'(1);
            end else begin
               shreg_nxt = {rxd, shreg[7:1]};
               cnt_nxt   = CW'(P);
               bit_nxt   = bit_idx + 3'd1;
               if (bit_idx == 3'd7)
                  state_nxt = STOP;
            end
         end
         STOP: begin
            if (!expired) begin
               cnt_nxt = cnt - CW'(1);
            end else if (rxd) begin
               data_nxt  = shreg;
               vld_nxt   = 1'b1;
               state_nxt = IDLE;
            end else begin
               ferr_nxt  = 1'b1;
               state_nxt = WAITHIGH;
            end
         end
         WAITHIGH: begin
            if (rxd)
               state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: rtl/rs232in_hex.sv
// RS232 hex-line parser; word_valid pulses one cycle after the byte_valid of the closing LF.
// No backpressure: results are single-cycle pulses and word/nibbles hold until the next line.
module rs232in_hex
   import rs232in_hex_pkg::*;
#(
   parameter int frequency = 50_000_000,
   parameter int bps       = 115_200
) (
   input  logic           clock,
   input  logic           reset,
   rs232in_hex_if.master  bus
);
   logic [35:0] acc;
   logic [3:0]  cnt;
   logic        ovf;
   logic [4:0]  hx;

   rs232in #(.frequency(frequency), .bps(bps)) u_rx (
      .clock         (clock),
      .reset         (reset),
      .serial_in     (bus.serial_in),
      .byte_data     (bus.byte_data),
      .byte_valid    (bus.byte_valid),
      .framing_error (bus.framing_error)
   );

   assign hx = hex_decode(bus.byte_data);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         acc               <= '0;
         cnt               <= '0;
         ovf               <= 1'b0;
         bus.word          <= '0;
         bus.nibbles       <= '0;
         bus.word_overflow <= 1'b0;
         bus.word_valid    <= 1'b0;
      end else begin
         bus.word_valid <= 1'b0;
         if (bus.byte_valid) begin
            if (hx[4]) begin
               // Digits beyond the ninth are dropped but remembered as overflow
               if (cnt < 4'd9) begin
                  acc <= {acc[31:0], hx[3:0]};
                  cnt <= cnt + 4'd1;
               end else begin
                  ovf <= 1'b1;
               end
            end else if (bus.byte_data == CR) begin
               acc <= acc;
            end else begin
               if (bus.byte_data == LF && cnt != 4'd0) begin
                  bus.word          <= acc;
                  bus.nibbles       <= cnt;
                  bus.word_overflow <= ovf;
                  bus.word_valid    <= 1'b1;
               end
               acc <= '0;
               cnt <= '0;
               ovf <= 1'b0;
            end
         end
      end
   end

endmodule
